// File: rtl/fsl_tx_arbiter_pkg.sv
// Shared definitions for the FSL-to-RS232 transmit arbiter: FSM state
// encoding, the tag byte base value and the burst counter width.
package fsl_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TAG,
    SEND,
    HOLD,
    WAIT
  } state_t;

  // Tag bytes are TAG_BASE with the channel number in the low bit.
  localparam logic [7:0] TAG_BASE = 8'hF0;

  // Burst counter width; MAX_BURST must fit (1..15).
  localparam int BURST_W = 4;

  // Tag byte announcing the start of a grant for channel ch.
  function automatic logic [7:0] tag_byte(input logic ch);
    return TAG_BASE | {7'b0000000, ch};
  endfunction

endpackage

// File: rtl/fsl_tx_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// channel that was not served last wins. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  // Grant selection from the request pair and the last served channel.
  always_comb begin
    valid = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/fsl_tx_arbiter.sv
// Arbitrates two FSL slave channels onto one RS232 byte transmitter.
// A granted channel sends up to MAX_BURST words, one start pulse per word,
// each pulse followed by a one-cycle HOLD that covers the transmitter's
// ready drop, then WAIT until the transmitter is idle again.
// Optional feature macro FSL_TX_TAG_EN: each grant is preceded by a tag
// byte (TAG_BASE | channel) sent without popping the FSL channel.
module fsl_tx_arbiter
  import fsl_tx_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clock,
  input  logic       reset,
  output logic       FSL0_S_CLK,
  output logic       FSL1_S_CLK,
  input  logic [0:7] FSL0_S_DATA,
  input  logic [0:7] FSL1_S_DATA,
  input  logic       FSL0_S_EXISTS,
  input  logic       FSL1_S_EXISTS,
  output logic       FSL0_S_READ,
  output logic       FSL1_S_READ,
  input  logic       rs232_tx_ready,
  output logic [7:0] rs232_tx_data,
  output logic       rs232_tx_start,
  output logic       grant_ch
);

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

  state_t             state;
  logic [BURST_W-1:0] burst;
  logic               last_served;

  logic [1:0] req;
  logic       arb_last;
  logic       arb_grant;
  logic       arb_valid;
  logic [7:0] arb_data;
  logic [7:0] cur_data;
  logic       cur_exists;
  logic       wait_done;
  logic       burst_more;
  logic       do_continue;
  logic       do_grant;

  assign FSL0_S_CLK = clock;
  assign FSL1_S_CLK = clock;

  assign req = {FSL1_S_EXISTS, FSL0_S_EXISTS};

  // Leaving WAIT ends the current grant, so the channel just served counts
  // as "last" for the same-cycle re-arbitration.
  assign arb_last = (state == WAIT) ? grant_ch : last_served;

  rr_arb2 u_arb (
    .req   (req),
    .last  (arb_last),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // FSL words are declared [0:7]; a plain vector copy puts FSL bit 0 on
  // rs232 bit 7, which is the required bit mapping.
  assign arb_data   = arb_grant ? FSL1_S_DATA : FSL0_S_DATA;
  assign cur_data   = grant_ch ? FSL1_S_DATA : FSL0_S_DATA;
  assign cur_exists = grant_ch ? FSL1_S_EXISTS : FSL0_S_EXISTS;

  assign wait_done   = (state == WAIT) && rs232_tx_ready;
  assign burst_more  = (burst < MAX_B) && cur_exists;
  assign do_continue = wait_done && burst_more;
  assign do_grant    = rs232_tx_ready && arb_valid &&
                       ((state == IDLE) || (wait_done && !burst_more));

  // Control FSM with registered start/data/read outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      rs232_tx_start <= 1'b0;
      rs232_tx_data  <= 8'h00;
      FSL0_S_READ    <= 1'b0;
      FSL1_S_READ    <= 1'b0;
      burst          <= '0;
      grant_ch       <= 1'b0;
      last_served    <= 1'b1;
    end else begin
      rs232_tx_start <= 1'b0;
      FSL0_S_READ    <= 1'b0;
      FSL1_S_READ    <= 1'b0;
      if (do_grant) begin
        grant_ch <= arb_grant;
        if (state == WAIT) last_served <= grant_ch;
`ifdef FSL_TX_TAG_EN
        state          <= TAG;
        burst          <= '0;
        rs232_tx_start <= 1'b1;
        rs232_tx_data  <= tag_byte(arb_grant);
`else
        // Counter clears on grant and counts this first SEND at once.
        state          <= SEND;
        burst          <= BURST_W'(1);
        rs232_tx_start <= 1'b1;
        rs232_tx_data  <= arb_data;
        FSL0_S_READ    <= ~arb_grant;
        FSL1_S_READ    <= arb_grant;
`endif
      end else if (do_continue) begin
        state          <= SEND;
        burst          <= burst + 1'b1;
        rs232_tx_start <= 1'b1;
        rs232_tx_data  <= cur_data;
        FSL0_S_READ    <= ~grant_ch;
        FSL1_S_READ    <= grant_ch;
      end else begin
        case (state)
          TAG, SEND: state <= HOLD;
          HOLD:      state <= WAIT;
          WAIT: begin
            if (rs232_tx_ready) begin
              state       <= IDLE;
              last_served <= grant_ch;
            end
          end
          default:   state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsl_tx_arbiter.sv
// Directed bench for fsl_tx_arbiter: FSL FIFO and transmitter models drive
// the inputs, a monitor logs each start pulse, each test compares the log
// with a hand-written expected byte stream.
`timescale 1ns/1ps
module tb_fsl_tx_arbiter;
  import fsl_tx_arbiter_pkg::*;

`ifdef FSL_TX_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       FSL0_S_CLK, FSL1_S_CLK;
  logic [0:7] FSL0_S_DATA = 8'h00;
  logic [0:7] FSL1_S_DATA = 8'h00;
  logic       FSL0_S_EXISTS = 1'b0;
  logic       FSL1_S_EXISTS = 1'b0;
  logic       FSL0_S_READ, FSL1_S_READ;
  logic       rs232_tx_ready = 1'b1;
  logic [7:0] rs232_tx_data;
  logic       rs232_tx_start;
  logic       grant_ch;

  int total = 0;
  int bad = 0;

  logic [7:0] fifo0[$];
  logic [7:0] fifo1[$];
  logic [7:0] bytes[$];
  int         chans[$];
  logic       gchs[$];
  logic [7:0] exp_bytes[$];
  int         exp_chans[$];
  logic       exp_g[$];

  int   busy = 0;
  int   tx_lat = 10;
  bit   stall = 1'b0;
  logic prev_start = 1'b0;
  int   viol_consec = 0;
  int   viol_both = 0;
  int   viol_empty = 0;

  always #5 clock = ~clock;

  fsl_tx_arbiter #(.MAX_BURST(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .FSL0_S_CLK     (FSL0_S_CLK),
    .FSL1_S_CLK     (FSL1_S_CLK),
    .FSL0_S_DATA    (FSL0_S_DATA),
    .FSL1_S_DATA    (FSL1_S_DATA),
    .FSL0_S_EXISTS  (FSL0_S_EXISTS),
    .FSL1_S_EXISTS  (FSL1_S_EXISTS),
    .FSL0_S_READ    (FSL0_S_READ),
    .FSL1_S_READ    (FSL1_S_READ),
    .rs232_tx_ready (rs232_tx_ready),
    .rs232_tx_data  (rs232_tx_data),
    .rs232_tx_start (rs232_tx_start),
    .grant_ch       (grant_ch)
  );

  // Environment: logs start pulses, models transmitter busy time and FSL FIFOs.
  always begin
    @(posedge clock);
    #1;
    if (reset) begin
      busy = 0;
      prev_start = 1'b0;
    end else begin
      if (rs232_tx_start) begin
        bytes.push_back(rs232_tx_data);
        chans.push_back(FSL1_S_READ ? 2 : (FSL0_S_READ ? 1 : 0));
        gchs.push_back(grant_ch);
        if (prev_start) viol_consec++;
        busy = tx_lat;
      end else if (busy > 0) begin
        busy--;
      end
      prev_start = rs232_tx_start;
    end
    if (FSL0_S_READ && FSL1_S_READ) viol_both++;
    if (FSL0_S_READ && !FSL0_S_EXISTS) viol_empty++;
    if (FSL1_S_READ && !FSL1_S_EXISTS) viol_empty++;
    if (FSL0_S_READ && fifo0.size() > 0) void'(fifo0.pop_front());
    if (FSL1_S_READ && fifo1.size() > 0) void'(fifo1.pop_front());
    FSL0_S_EXISTS  = (fifo0.size() > 0);
    FSL1_S_EXISTS  = (fifo1.size() > 0);
    FSL0_S_DATA    = FSL0_S_EXISTS ? fifo0[0] : 8'h00;
    FSL1_S_DATA    = FSL1_S_EXISTS ? fifo1[0] : 8'h00;
    rs232_tx_ready = (busy == 0) && !stall;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    fifo0.delete();
    fifo1.delete();
    tick(2);
    bytes.delete(); chans.delete(); gchs.delete();
    exp_bytes.delete(); exp_chans.delete(); exp_g.delete();
    viol_consec = 0; viol_both = 0; viol_empty = 0;
    reset = 1'b0;
  endtask

  task automatic exp_grant(input logic ch);
    if (TAG_EN) begin
      exp_bytes.push_back(8'hF0 | {7'b0000000, ch});
      exp_chans.push_back(0);
      exp_g.push_back(ch);
    end
  endtask

  task automatic exp_word(input logic ch, input logic [7:0] v);
    exp_bytes.push_back(v);
    exp_chans.push_back(ch ? 2 : 1);
    exp_g.push_back(ch);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    total++;
    if ({rs232_tx_start, FSL0_S_READ, FSL1_S_READ, grant_ch} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: start/rd0/rd1/grant=%b required 0000",
               {rs232_tx_start, FSL0_S_READ, FSL1_S_READ, grant_ch});
    end
    total++;
    if (rs232_tx_data !== 8'h00) begin
      bad++; $display("FAIL reset_data: got %h required 00", rs232_tx_data);
    end
    total++;
    if (dut.state !== IDLE) begin
      bad++; $display("FAIL reset_state: got %0d required %0d", dut.state, IDLE);
    end
    total++;
    if (FSL0_S_CLK !== 1'b1 || FSL1_S_CLK !== 1'b1) begin
      bad++; $display("FAIL clk_high: got %b%b required 11", FSL0_S_CLK, FSL1_S_CLK);
    end
    @(negedge clock);
    #1;
    total++;
    if (FSL0_S_CLK !== 1'b0 || FSL1_S_CLK !== 1'b0) begin
      bad++; $display("FAIL clk_low: got %b%b required 00", FSL0_S_CLK, FSL1_S_CLK);
    end
  endtask

  task automatic test_single();
    do_reset();
    tx_lat = 10;
    fifo0.push_back(8'hA0); fifo0.push_back(8'hA1); fifo0.push_back(8'hA2);
    exp_grant(1'b0);
    exp_word(1'b0, 8'hA0); exp_word(1'b0, 8'hA1); exp_word(1'b0, 8'hA2);
    tick(100);
    total++;
    if (bytes.size() !== exp_bytes.size()) begin
      bad++; $display("FAIL single_count: got %0d required %0d", bytes.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size(); i++) begin
      total++;
      if (i >= bytes.size() || bytes[i] !== exp_bytes[i] || chans[i] !== exp_chans[i]) begin
        bad++;
        $display("FAIL single_byte[%0d]: got %h/rd%0d required %h/rd%0d", i,
                 (i < bytes.size()) ? bytes[i] : 8'hxx, (i < chans.size()) ? chans[i] : -1,
                 exp_bytes[i], exp_chans[i]);
      end
    end
    total++;
    if (viol_consec + viol_both + viol_empty !== 0) begin
      bad++; $display("FAIL single_protocol: violations %0d/%0d/%0d required 0/0/0",
                      viol_consec, viol_both, viol_empty);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    tx_lat = 3;
    for (int i = 0; i < 8; i++) begin
      fifo0.push_back(8'h10 + 8'(i));
      fifo1.push_back(8'h20 + 8'(i));
    end
    exp_grant(1'b0);
    for (int i = 0; i < 4; i++) exp_word(1'b0, 8'h10 + 8'(i));
    exp_grant(1'b1);
    for (int i = 0; i < 4; i++) exp_word(1'b1, 8'h20 + 8'(i));
    exp_grant(1'b0);
    for (int i = 4; i < 8; i++) exp_word(1'b0, 8'h10 + 8'(i));
    exp_grant(1'b1);
    for (int i = 4; i < 8; i++) exp_word(1'b1, 8'h20 + 8'(i));
    tick(200);
    total++;
    if (bytes.size() !== exp_bytes.size()) begin
      bad++; $display("FAIL alt_count: got %0d required %0d", bytes.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size(); i++) begin
      total++;
      if (i >= bytes.size() || bytes[i] !== exp_bytes[i] || chans[i] !== exp_chans[i] ||
          gchs[i] !== exp_g[i]) begin
        bad++;
        $display("FAIL alt_byte[%0d]: got %h/rd%0d/g%b required %h/rd%0d/g%b", i,
                 (i < bytes.size()) ? bytes[i] : 8'hxx, (i < chans.size()) ? chans[i] : -1,
                 (i < gchs.size()) ? gchs[i] : 1'bx, exp_bytes[i], exp_chans[i], exp_g[i]);
      end
    end
    total++;
    if (viol_consec + viol_both + viol_empty !== 0) begin
      bad++; $display("FAIL alt_protocol: violations %0d/%0d/%0d required 0/0/0",
                      viol_consec, viol_both, viol_empty);
    end
  endtask

  task automatic test_lone_and_tie();
    do_reset();
    tx_lat = 3;
    fifo1.push_back(8'h5A);
    exp_grant(1'b1); exp_word(1'b1, 8'h5A);
    tick(25);
    fifo0.push_back(8'h61);
    fifo1.push_back(8'h62);
    exp_grant(1'b0); exp_word(1'b0, 8'h61);
    exp_grant(1'b1); exp_word(1'b1, 8'h62);
    tick(50);
    total++;
    if (bytes.size() !== exp_bytes.size()) begin
      bad++; $display("FAIL tie_count: got %0d required %0d", bytes.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size(); i++) begin
      total++;
      if (i >= bytes.size() || bytes[i] !== exp_bytes[i] || chans[i] !== exp_chans[i]) begin
        bad++;
        $display("FAIL tie_byte[%0d]: got %h/rd%0d required %h/rd%0d", i,
                 (i < bytes.size()) ? bytes[i] : 8'hxx, (i < chans.size()) ? chans[i] : -1,
                 exp_bytes[i], exp_chans[i]);
      end
    end
  endtask

  task automatic test_exists_drop();
    do_reset();
    tx_lat = 3;
    fifo0.push_back(8'h30); fifo0.push_back(8'h31);
    fifo1.push_back(8'h40); fifo1.push_back(8'h41); fifo1.push_back(8'h42);
    exp_grant(1'b0); exp_word(1'b0, 8'h30); exp_word(1'b0, 8'h31);
    exp_grant(1'b1); exp_word(1'b1, 8'h40); exp_word(1'b1, 8'h41); exp_word(1'b1, 8'h42);
    tick(100);
    total++;
    if (bytes.size() !== exp_bytes.size()) begin
      bad++; $display("FAIL drop_count: got %0d required %0d", bytes.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size(); i++) begin
      total++;
      if (i >= bytes.size() || bytes[i] !== exp_bytes[i] || chans[i] !== exp_chans[i]) begin
        bad++;
        $display("FAIL drop_byte[%0d]: got %h/rd%0d required %h/rd%0d", i,
                 (i < bytes.size()) ? bytes[i] : 8'hxx, (i < chans.size()) ? chans[i] : -1,
                 exp_bytes[i], exp_chans[i]);
      end
    end
    total++;
    if (viol_empty !== 0) begin
      bad++; $display("FAIL drop_read_empty: got %0d required 0", viol_empty);
    end
  endtask

  task automatic test_stall_reset();
    int n;
    int waited;
    do_reset();
    tx_lat = 4;
    for (int i = 0; i < 6; i++) fifo1.push_back(8'h71 + 8'(i));
    waited = 0;
    while (bytes.size() < 2 && waited < 100) begin
      tick(1);
      waited++;
    end
    total++;
    if (bytes.size() < 2) begin
      bad++; $display("FAIL stall_start: got %0d pulses required 2 within 100 cycles", bytes.size());
    end
    stall = 1'b1;
    n = bytes.size();
    tick(100);
    total++;
    if (bytes.size() !== n) begin
      bad++; $display("FAIL stall_pulses: got %0d pulses required %0d", bytes.size(), n);
    end
    total++;
    if (dut.state !== WAIT) begin
      bad++; $display("FAIL stall_state: got %0d required %0d", dut.state, WAIT);
    end
    total++;
    if (grant_ch !== 1'b1) begin
      bad++; $display("FAIL stall_grant: got %b required 1", grant_ch);
    end
    reset = 1'b1;
    tick(1);
    total++;
    if ({rs232_tx_start, FSL0_S_READ, FSL1_S_READ, grant_ch} !== 4'b0000 ||
        rs232_tx_data !== 8'h00) begin
      bad++;
      $display("FAIL stall_reset_out: start/rd0/rd1/grant=%b data=%h required 0000 00",
               {rs232_tx_start, FSL0_S_READ, FSL1_S_READ, grant_ch}, rs232_tx_data);
    end
    total++;
    if (dut.state !== IDLE) begin
      bad++; $display("FAIL stall_reset_state: got %0d required %0d", dut.state, IDLE);
    end
    stall = 1'b0;
    fifo1.delete();
    reset = 1'b0;
    tick(1);
    total++;
    if ({rs232_tx_start, FSL0_S_READ, FSL1_S_READ} !== 3'b000) begin
      bad++; $display("FAIL post_reset_pulse: start/rd0/rd1=%b required 000",
                      {rs232_tx_start, FSL0_S_READ, FSL1_S_READ});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_lone_and_tie();
    test_exists_drop();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsl_tx_arbiter.md
FSL_TX_ARBITER -- requirements
Module: fsl_tx_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: maximum words sent from one channel per grant, legal range 1..15.
REQ-002 SHALL have port clock, input, 1: single clock for all logic; also driven out on FSL0_S_CLK and FSL1_S_CLK.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports FSL0_S_CLK and FSL1_S_CLK, output, 1 each: FSL slave clocks, equal to clock.
REQ-005 SHALL have ports FSL0_S_DATA and FSL1_S_DATA, input, [0:7] each: head word of each FSL channel.
REQ-006 SHALL have ports FSL0_S_EXISTS and FSL1_S_EXISTS, input, 1 each: channel FIFO non-empty.
REQ-007 SHALL have ports FSL0_S_READ and FSL1_S_READ, output, 1 each: one-cycle pop pulse per channel.
REQ-008 SHALL have port rs232_tx_ready, input, 1: transmitter idle and able to accept a byte.
REQ-009 SHALL have port rs232_tx_data, output, [7:0]: byte to transmit; FSL bit 0 maps to rs232 bit 7.
REQ-010 SHALL have port rs232_tx_start, output, 1: one-cycle start pulse for the transmitter.
REQ-011 SHALL have port grant_ch, output, 1: currently or last granted channel.

Function
REQ-012 SHALL implement the FSM states IDLE, TAG, SEND, HOLD and WAIT.
REQ-013 IDLE SHALL, with rs232_tx_ready=1 and at least one EXISTS high, grant a channel by round robin: the channel other than the last served wins ties; a lone requester always wins.
REQ-014 On grant, the FSM SHALL clear the burst counter, set grant_ch, and go to TAG if FSL_TX_TAG_EN is defined, otherwise to SEND.
REQ-015 SEND SHALL last exactly one cycle and assert registered rs232_tx_start=1, rs232_tx_data=granted DATA captured on the entering edge, and the granted FSLn_S_READ=1. Only one READ SHALL ever be high.
REQ-016 SEND SHALL be entered only when rs232_tx_ready=1 and the granted EXISTS=1 were sampled on the entering edge.
REQ-017 HOLD SHALL last one cycle after any start pulse, absorbing the transmitter's ready drop, and then go to WAIT.
REQ-018 WAIT SHALL remain until rs232_tx_ready=1. Then:
- go to SEND, same channel, if burst count < MAX_BURST and the granted EXISTS=1;
- otherwise end the grant, record the last served channel, and re-arbitrate as in IDLE in the same cycle.
REQ-019 The burst counter SHALL increment on each SEND (not on TAG) and be 4 bits wide.
REQ-020 rs232_tx_start SHALL never be asserted on two consecutive cycles.
REQ-021 READ SHALL never be asserted for a channel whose EXISTS was 0 at the prior edge.
REQ-022 A channel whose EXISTS drops during a grant SHALL lose the grant at the next WAIT exit; no stall.
REQ-023 A transmitter that holds rs232_tx_ready=0 indefinitely SHALL hold the FSM in WAIT with no pulses.

Reset
REQ-024 On reset=1 at a clock edge, the block SHALL set:
- FSM=IDLE;
- rs232_tx_start=0, rs232_tx_data=8'h00;
- FSL0_S_READ=0, FSL1_S_READ=0;
- burst counter=0, grant_ch=0, last served=1 (channel 0 wins the first tie).
REQ-025 Reset mid-transfer SHALL abandon the grant; no start or READ pulse SHALL follow on the next cycle.

Configuration
REQ-026 With macro FSL_TX_TAG_EN defined, TAG SHALL emit one start pulse with rs232_tx_data=8'hF0|grant_ch and no READ, then go to HOLD. TAG requires rs232_tx_ready=1 and is emitted once per grant.
REQ-027 Without FSL_TX_TAG_EN, TAG SHALL be absent and no tag bytes SHALL be emitted.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the TAG_BASE constant 8'hF0 and the burst counter width.
REQ-029 The round-robin two-way arbiter SHALL be a sub-module rr_arb2 (req[1:0], last, grant, valid), purely combinational.

Verification
REQ-030 Ch0 only, EXISTS with 3 words A0,A1,A2 and tx_ready returning 10 cycles after each start -> 3 start pulses carrying A0,A1,A2, FSL0_S_READ coincident with each, and FSL1_S_READ never asserted.
REQ-031 Both channels continuously EXISTS, MAX_BURST=4 -> bursts of 4 words alternate ch0, ch1, ch0; grant_ch toggles per burst.
REQ-032 Simultaneous first requests after reset -> ch0 granted first; a tie after serving ch0 -> ch1 granted.
REQ-033 FSL_TX_TAG_EN defined, ch1 sends 2 words 11,22 -> rs232 byte stream F1,11,22.
REQ-034 rs232_tx_ready held 0 for 100 cycles mid-burst, then reset asserted -> no pulses during the stall; all outputs 0 and FSM IDLE the cycle after reset.
